// File: rtl/xor_stream_decoder_pkg.sv
// Shared constants for the XOR keystream decoder/encoder pair:
// LFSR taps, zero-seed substitute and controller state encodings.
package xor_stream_decoder_pkg;

  // Taps at bits 15, 13, 12 and 10 of the Fibonacci LFSR.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;
  localparam logic [15:0] LFSR_RESET    = 16'h0001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  function automatic logic [15:0] seed_sanitize(input logic [15:0] seed);
    logic [15:0] res;
    if (seed == 16'h0000) begin
      res = LFSR_ZERO_SUB;
    end else begin
      res = seed;
    end
    return res;
  endfunction

endpackage

// File: rtl/xor_stream_decoder_lfsr16_step.sv
// One combinational step of the 16-bit Fibonacci keystream LFSR.
// Shared by the decoder and the matching encoder.
module lfsr16_step
  import xor_stream_decoder_pkg::*;
(
  input  logic [15:0] state_i,
  output logic [15:0] next_o
);

  logic fb_s;

  // Feedback is the XOR of the tapped bits, shifted in at the LSB.
  always_comb begin
    fb_s   = ^(state_i & LFSR_TAPS);
    next_o = {state_i[14:0], fb_s};
  end

endmodule

// File: rtl/xor_stream_decoder.sv
// Streaming XOR decoder: plaintext = ciphertext ^ LFSR keystream, with a
// single output register acting as a one-deep valid/ready pipeline stage.
module xor_stream_decoder
  import xor_stream_decoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [15:0]  seed,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic         locked,
  output logic [15:0]  word_count
);

  state_e       state_q, state_d;
  logic [15:0]  lfsr_q, lfsr_d, lfsr_next_s;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [15:0]  word_count_q, word_count_d;
  logic         locked_s, in_xfer_s, out_xfer_s;

  lfsr16_step u_step (
    .state_i (lfsr_q),
    .next_o  (lfsr_next_s)
  );

  // State and datapath registers; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_RESET;
      out_valid_q  <= 1'b0;
      out_data_q   <= {N{1'b0}};
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  // Next controller state: a seed load is the only way into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller outputs and handshake qualifiers.
  always_comb begin
    locked_s   = 1'b0;
    case (state_q)
      ST_IDLE: locked_s = 1'b0;
      ST_RUN:  locked_s = 1'b1;
      default: locked_s = 1'b0;
    endcase
    in_ready   = locked_s & ~seed_load & (~out_valid_q | out_ready);
    in_xfer_s  = in_valid & in_ready;
    out_xfer_s = out_valid_q & out_ready;
  end

  // Datapath next state; seed_load discards the held word and wins over input.
  always_comb begin
    lfsr_d       = lfsr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;
    if (seed_load) begin
      lfsr_d       = seed_sanitize(seed);
      out_valid_d  = 1'b0;
      word_count_d = 16'd0;
    end else if (in_xfer_s) begin
      lfsr_d       = lfsr_next_s;
      out_valid_d  = 1'b1;
      out_data_d   = in_data ^ lfsr_q[N-1:0];
      word_count_d = word_count_q + 16'd1;
    end else if (out_xfer_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  assign locked     = locked_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Directed self-checking bench for xor_stream_decoder (N=8) with
// hand-computed keystream values for seed 16'hACE1.
module tb_xor_stream_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        locked;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Keystream low bytes of states 1..4 after seed ACE1 (ACE1,59C3,B387,670F,CE1E).
  logic [7:0] ks_tbl [4] = '{8'hC3, 8'h87, 8'h0F, 8'h1E};

  xor_stream_decoder #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .locked     (locked),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ov"}, 16'(out_valid), 16'd0);
    check({tag, "_od"}, 16'(out_data), 16'd0);
    check({tag, "_wc"}, word_count, 16'd0);
    check({tag, "_lk"}, 16'(locked), 16'd0);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = 16'h0000;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_values("reset");
    check("reset_ir", 16'(in_ready), 16'd0);

    // IDLE ignores input
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle_ir", 16'(in_ready), 16'd0);
      tick();
      check("idle_ov", 16'(out_valid), 16'd0);
      check("idle_lk", 16'(locked), 16'd0);
    end

    // Seed ACE1, words 00 and FF
    load_seed(16'hACE1);
    check("run_lk", 16'(locked), 16'd1);
    out_ready = 1'b1; in_data = 8'h00;
    #1;
    check("run_ir", 16'(in_ready), 16'd1);
    tick();
    check("w0_ov", 16'(out_valid), 16'd1);
    check("w0_od", 16'(out_data), 16'h00E1);
    check("w0_wc", word_count, 16'd1);
    in_data = 8'hFF;
    tick();
    check("w1_od", 16'(out_data), 16'h003C);
    check("w1_wc", word_count, 16'd2);
    in_valid = 1'b0;
    tick();
    check("drain_ov", 16'(out_valid), 16'd0);
    check("drain_wc", word_count, 16'd2);

    // Zero seed substitutes 0001
    load_seed(16'h0000);
    check("zs_wc", word_count, 16'd0);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    check("zs_od", 16'(out_data), 16'h0001);
    in_valid = 1'b0;
    tick();

    // Backpressure then back-to-back
    load_seed(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    tick();
    check("bp_od0", 16'(out_data), 16'h00E1);
    for (int i = 0; i < 4; i++) begin
      check("bp_ir", 16'(in_ready), 16'd0);
      tick();
      check("bp_od", 16'(out_data), 16'h00E1);
      check("bp_ov", 16'(out_valid), 16'd1);
      check("bp_wc", word_count, 16'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("b2b_ir", 16'(in_ready), 16'd1);
      tick();
      check("b2b_ov", 16'(out_valid), 16'd1);
      check("b2b_od", 16'(out_data), 16'(ks_tbl[i]));
    end
    check("b2b_wc", word_count, 16'd5);
    in_valid = 1'b0;
    tick();
    check("b2b_end_ov", 16'(out_valid), 16'd0);

    // Seed load while holding a word with input pending
    load_seed(16'hACE1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    tick();
    check("sl_hold_ov", 16'(out_valid), 16'd1);
    seed_load = 1'b1; seed = 16'h1234;
    #1;
    check("sl_ir", 16'(in_ready), 16'd0);
    tick();
    seed_load = 1'b0;
    check("sl_ov", 16'(out_valid), 16'd0);
    check("sl_wc", word_count, 16'd0);
    out_ready = 1'b1;
    tick();
    check("sl_od", 16'(out_data), 16'h0034);
    check("sl_wc1", word_count, 16'd1);

    // Counter wrap after 65536 words
    repeat (65535) tick();
    check("wrap_wc", word_count, 16'd0);
    check("wrap_ov", 16'(out_valid), 16'd1);

    // Reset mid-stream overrides a simultaneous seed load
    rst = 1'b1; seed_load = 1'b1; seed = 16'h5555;
    tick();
    rst = 1'b0; seed_load = 1'b0;
    check_reset_values("midrst");
    #1;
    check("midrst_ir", 16'(in_ready), 16'd0);
    tick();
    check("midrst_ov2", 16'(out_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_stream_decoder.md
XOR_STREAM_DECODER -- requirements
Module: xor_stream_decoder

Interface
REQ-001 Parameter N, default 8, SHALL set the data word width; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 seed_load  input  1  one-cycle pulse; loads a new keystream seed.
REQ-005 seed  input  16  seed value, sampled when seed_load=1.
REQ-006 in_valid  input  1  ciphertext word present.
REQ-007 in_data  input  N  ciphertext word.
REQ-008 in_ready  output  1  decoder accepts in_data this cycle.
REQ-009 out_valid  output  1  plaintext word present.
REQ-010 out_data  output  N  plaintext word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 locked  output  1  high in RUN state.
REQ-013 word_count  output  16  number of words accepted since the last seed_load.

Function
REQ-014 The block SHALL have two states: IDLE (no seed) and RUN.
REQ-015 Transfers: an input transfer occurs when in_valid=1 and in_ready=1; an output transfer occurs when out_valid=1 and out_ready=1.
REQ-016 The keystream SHALL come from a 16-bit Fibonacci LFSR with feedback fb = s[15]^s[13]^s[12]^s[10] and next state {s[14:0], fb}.
REQ-017 On seed_load, the LFSR SHALL load seed, or 16'h0001 if seed==0.
REQ-018 On seed_load, the block SHALL also enter RUN, clear out_valid, and clear word_count, in either state.
REQ-019 in_ready SHALL equal locked & ~seed_load & (~out_valid | out_ready), combinationally.
REQ-020 On an input transfer, the block SHALL capture out_data <= in_data ^ s[N-1:0] at the next edge and set out_valid=1, for a latency of one cycle.
REQ-021 On an input transfer, the LFSR SHALL advance exactly one step and word_count SHALL increment, wrapping from 16'hFFFF to 0.
REQ-022 When no input transfer occurs, the LFSR and word_count SHALL hold.
REQ-023 On an output transfer with no simultaneous input transfer, out_valid SHALL clear.
REQ-024 On a simultaneous input and output transfer, out_valid SHALL stay 1 and out_data SHALL take the new word, with no bubble.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-026 In IDLE, in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-027 seed_load SHALL take priority over a pending in_valid in the same cycle: no word is accepted in that cycle, and the previously held output word is discarded.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL go to IDLE with LFSR=16'h0001, out_valid=0, out_data=0, word_count=0, locked=0.
REQ-029 rst SHALL override seed_load and any transfer in the same cycle.
REQ-030 A reset asserted mid-stream SHALL discard any held word.

Structure
REQ-031 The LFSR tap constants, the zero-seed substitute (16'h0001), and the IDLE/RUN state encodings SHALL reside in a shared package/header.
REQ-032 The LFSR step SHALL be a sub-module, lfsr16_step, that is combinational, maps 16-bit state to next state, and is reused by the matching encoder.
REQ-033 The output register SHALL be the only data storage, with no further buffering.

Verification
REQ-034 Scenario: rst, then in_valid=1 without seed_load -> in_ready=0, out_valid=0, locked=0 for 10 cycles.
REQ-035 Scenario: N=8, seed_load with seed=16'hACE1, then in_data=8'h00 then 8'hFF with out_ready=1 -> out_data=8'hE1 then 8'h3C, each one cycle after acceptance; word_count=2.
REQ-036 Scenario: seed=16'h0000 -> LFSR=16'h0001; first in_data=8'h00 -> out_data=8'h01.
REQ-037 Scenario: out_ready held 0 for 5 cycles with in_valid=1 -> exactly one word accepted, out_data stable, in_ready=0; then out_ready=1 for 4 cycles with in_valid=1 -> 4 back-to-back transfers with no bubble.
REQ-038 Scenario: seed_load while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, word_count=0, and the next accepted word uses the new seed's keystream.
REQ-039 Scenario: 65536 accepted words -> word_count wraps to 0; rst mid-stream -> all outputs return to the REQ-028 values at the next edge.
